// File: rtl/heading_bank.sv
// heading_bank
//   Parametrised heading loader. While request_i is high a session is open;
//   each sampled rising edge of confirm_i captures one payload word from
//   input_data_i into the next heading register, in order 0..NUM_REGS-1.
//   Once every register is loaded the bank is FULL and ignores further
//   presses until request_i drops. Registered contents stay visible to the
//   display/nav datapath between sessions.
//
// Optional feature: define PARITY_CHECK_EN to require even parity over all
//   DATA_W+1 input bits. A rejected word is not captured and pulses
//   parity_err_o for one cycle. Without the macro the parity bit is ignored
//   and parity_err_o is tied low.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset, clears everything
//   request_i      session open while high
//   confirm_i      key input, a sampled rising edge captures one word
//   input_data_i   {parity, payload}, DATA_W+1 bits
//   data_out_o     register k at [k*DATA_W +: DATA_W]
//   valid_mask_o   bit k set once register k loaded in the current session
//   load_idx_o     index the next accepted word will load
//   busy_o         high in ARMED
//   done_o         high in FULL
//   parity_err_o   one-cycle pulse on a rejected word
//
// state | meaning
// IDLE  | no session open, contents held
// ARMED | session open, waiting for confirm presses
// FULL  | every register loaded, presses ignored

module heading_bank #(
    parameter int DATA_W   = 7,
    parameter int NUM_REGS = 2,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       request_i,
    input  logic                       confirm_i,
    input  logic [DATA_W:0]            input_data_i,
    output logic [NUM_REGS*DATA_W-1:0] data_out_o,
    output logic [NUM_REGS-1:0]        valid_mask_o,
    output logic [IDX_W-1:0]           load_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       parity_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       conf_prev_q;
    logic [NUM_REGS*DATA_W-1:0] data_q, data_d;
    logic [NUM_REGS-1:0]        mask_q, mask_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       perr_d;
    logic                       conf_edge;
    logic                       accept;

    // Previous confirm is tracked in every state, so a key already held
    // when the session opens never counts as a press.
    assign conf_edge = confirm_i & ~conf_prev_q;

`ifdef PARITY_CHECK_EN
    logic perr_q;
    assign accept       = ~(^input_data_i);
    assign parity_err_o = perr_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = input_data_i[DATA_W] | perr_d;
    assign accept        = 1'b1;
    assign parity_err_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        perr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request_i) begin
                    state_d = S_ARMED;
                    mask_d  = '0;
                    idx_d   = '0;
                end
            end
            S_ARMED: begin
                // Dropping request wins over a same-cycle press.
                if (!request_i) begin
                    state_d = S_IDLE;
                end else if (conf_edge) begin
                    if (accept) begin
                        data_d[int'(idx_q)*DATA_W +: DATA_W] = input_data_i[DATA_W-1:0];
                        mask_d[idx_q] = 1'b1;
                        if (idx_q == IDX_W'(NUM_REGS-1)) begin
                            state_d = S_FULL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (!request_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            conf_prev_q <= 1'b0;
            data_q      <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            conf_prev_q <= confirm_i;
            data_q      <= data_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
        end
    end

    assign data_out_o   = data_q;
    assign valid_mask_o = mask_q;
    assign load_idx_o   = idx_q;
    assign busy_o       = (state_q == S_ARMED);
    assign done_o       = (state_q == S_FULL);

endmodule

// File: tb/tb_heading_bank.sv
module tb_heading_bank;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    // Default instance: DATA_W=7, NUM_REGS=2
    logic        a_rst, a_req, a_conf;
    logic [7:0]  a_din;
    logic [13:0] a_dout;
    logic [1:0]  a_mask;
    logic [0:0]  a_idx;
    logic        a_busy, a_done, a_perr;

    // Wide instance: DATA_W=5, NUM_REGS=4
    logic        b_rst, b_req, b_conf;
    logic [5:0]  b_din;
    logic [19:0] b_dout;
    logic [3:0]  b_mask;
    logic [1:0]  b_idx;
    logic        b_busy, b_done, b_perr;

    heading_bank #(.DATA_W(7), .NUM_REGS(2)) dut_a (
        .clock_i      (clk),
        .reset_i      (a_rst),
        .request_i    (a_req),
        .confirm_i    (a_conf),
        .input_data_i (a_din),
        .data_out_o   (a_dout),
        .valid_mask_o (a_mask),
        .load_idx_o   (a_idx),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .parity_err_o (a_perr)
    );

    heading_bank #(.DATA_W(5), .NUM_REGS(4)) dut_b (
        .clock_i      (clk),
        .reset_i      (b_rst),
        .request_i    (b_req),
        .confirm_i    (b_conf),
        .input_data_i (b_din),
        .data_out_o   (b_dout),
        .valid_mask_o (b_mask),
        .load_idx_o   (b_idx),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .parity_err_o (b_perr)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic [13:0] dout, input logic [1:0] mask,
                         input logic idx, input logic busy, input logic done, input logic perr);
        chk({nm, " dout"}, 32'(a_dout), 32'(dout));
        chk({nm, " mask"}, 32'(a_mask), 32'(mask));
        chk({nm, " idx"},  32'(a_idx),  32'(idx));
        chk({nm, " busy"}, 32'(a_busy), 32'(busy));
        chk({nm, " done"}, 32'(a_done), 32'(done));
        chk({nm, " perr"}, 32'(a_perr), 32'(perr));
    endtask

    task automatic chk_b(input string nm, input logic [19:0] dout, input logic [3:0] mask,
                         input logic [1:0] idx, input logic busy, input logic done);
        chk({nm, " dout"}, 32'(b_dout), 32'(dout));
        chk({nm, " mask"}, 32'(b_mask), 32'(mask));
        chk({nm, " idx"},  32'(b_idx),  32'(idx));
        chk({nm, " busy"}, 32'(b_busy), 32'(busy));
        chk({nm, " done"}, 32'(b_done), 32'(done));
    endtask

    typedef struct {
        logic        req;
        logic        conf;
        logic [7:0]  din;
        logic [13:0] dout;
        logic [1:0]  mask;
        logic        idx;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // inputs applied, then state expected after the next rising edge
        //          req   conf  din    dout      mask   idx   busy  done
        vecs[0]  = '{1'b0, 1'b1, 8'h24, 14'h0000, 2'b00, 1'b0, 1'b0, 1'b0}; // press while idle
        vecs[1]  = '{1'b0, 1'b0, 8'h24, 14'h0000, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h24, 14'h0000, 2'b00, 1'b0, 1'b1, 1'b0}; // open session
        vecs[3]  = '{1'b1, 1'b1, 8'h24, 14'h0024, 2'b01, 1'b1, 1'b1, 1'b0}; // reg0 <- 24
        vecs[4]  = '{1'b1, 1'b0, 8'hB8, 14'h0024, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'hB8, 14'h1C24, 2'b11, 1'b1, 1'b0, 1'b1}; // reg1 <- 38, FULL
        vecs[6]  = '{1'b1, 1'b0, 8'h11, 14'h1C24, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'h11, 14'h1C24, 2'b11, 1'b1, 1'b0, 1'b1}; // ignored in FULL
        vecs[8]  = '{1'b0, 1'b0, 8'h11, 14'h1C24, 2'b11, 1'b1, 1'b0, 1'b0}; // IDLE, held
        vecs[9]  = '{1'b1, 1'b0, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0}; // re-arm clears mask/idx
        vecs[10] = '{1'b0, 1'b1, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b0, 1'b0}; // drop req with press
        vecs[11] = '{1'b1, 1'b1, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0}; // held key, not an edge
        vecs[12] = '{1'b1, 1'b1, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h11, 14'h1C24, 2'b00, 1'b0, 1'b1, 1'b0}; // release
        vecs[16] = '{1'b1, 1'b1, 8'h11, 14'h1C11, 2'b01, 1'b1, 1'b1, 1'b0}; // re-press, reg0 <- 11
        vecs[17] = '{1'b1, 1'b1, 8'h11, 14'h1C11, 2'b01, 1'b1, 1'b1, 1'b0}; // still held, once only

        a_rst = 1'b0; a_req = 1'b0; a_conf = 1'b0; a_din = 8'h00;
        b_rst = 1'b0; b_req = 1'b0; b_conf = 1'b0; b_din = 6'h00;

        // Reset, asserted away from a clock edge
        #5;
        a_rst = 1'b1; b_rst = 1'b1;
        #5;
        chk_a("reset", 14'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_b("reset_b", 20'h0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        a_rst = 1'b0; b_rst = 1'b0;

        // Table-driven session sequence
        for (int i = 0; i < 18; i++) begin
            a_req  = vecs[i].req;
            a_conf = vecs[i].conf;
            a_din  = vecs[i].din;
            tick();
            chk_a($sformatf("row%0d", i), vecs[i].dout, vecs[i].mask, vecs[i].idx,
                  vecs[i].busy, vecs[i].done, 1'b0);
        end

        // Parity handling
        a_req = 1'b0; a_conf = 1'b0;
        tick();
        a_rst = 1'b1;
        #1;
        a_rst = 1'b0;
        a_req = 1'b1;
        tick();
        chk_a("par_arm", 14'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        a_conf = 1'b1; a_din = 8'h38;
        tick();
`ifdef PARITY_CHECK_EN
        chk_a("par_rej", 14'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        a_conf = 1'b0;
        tick();
        chk_a("par_pulse_end", 14'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        a_conf = 1'b1; a_din = 8'hB8;
        tick();
        chk_a("par_acc", 14'h0038, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        chk_a("nopar_acc", 14'h0038, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        a_conf = 1'b0;
        tick();
        a_conf = 1'b1; a_din = 8'h3A;
        tick();
        chk_a("nopar_acc2", 14'h1D38, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

        // Wide instance: two loads then asynchronous reset
        b_req = 1'b1;
        tick();
        chk_b("b_arm", 20'h0, 4'b0000, 2'd0, 1'b1, 1'b0);
        b_conf = 1'b1; b_din = 6'h05;
        tick();
        chk_b("b_load0", 20'h00005, 4'b0001, 2'd1, 1'b1, 1'b0);
        b_conf = 1'b0;
        tick();
        b_conf = 1'b1; b_din = 6'h0A;
        tick();
        chk_b("b_load1", 20'h00145, 4'b0011, 2'd2, 1'b1, 1'b0);
        b_conf = 1'b0;
        #10;
        b_rst = 1'b1;
        #1;
        chk_b("b_async_rst", 20'h0, 4'b0000, 2'd0, 1'b0, 1'b0);
        #5;
        b_rst = 1'b0;

        // Request falling with a press: no capture
        tick();
        chk_b("b_rearm", 20'h0, 4'b0000, 2'd0, 1'b1, 1'b0);
        b_req = 1'b0; b_conf = 1'b1; b_din = 6'h05;
        tick();
        chk_b("b_abort", 20'h0, 4'b0000, 2'd0, 1'b0, 1'b0);
        b_req = 1'b1;
        tick();
        chk_b("b_after_abort", 20'h0, 4'b0000, 2'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
